sram_rw_arbiter: RTL and testbench
==================================

Name: sram_rw_arbiter

Overview:
- Shares one single-port read/write SRAM macro between two requesters, A and B. The macro has a 1-cycle registered read, en/wmode/wmask controls, and is sized like the data_arrays/tag_array macros.
- Provides round-robin arbitration, valid/ready request handshakes and 1-cycle read responses.
- After reset, optionally runs a zero-initialisation sweep before accepting requests.
- Sits between cache/directory pipelines and the `*_ext` RW SRAM macro.

Parameters:
- ADDR_W, 9, SRAM address width.
- DEPTH, 512, number of SRAM entries; DEPTH <= 2**ADDR_W.
- DATA_W, 128, SRAM word width.
- MASK_W, 4, write-mask lanes; DATA_W % MASK_W == 0.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- a_req_valid  in  1  requester A has a request.
- a_req_ready  out  1  A's request is granted this cycle.
- a_req_write  in  1  1 = write, 0 = read.
- a_req_addr  in  ADDR_W  request address.
- a_req_wdata  in  DATA_W  write data.
- a_req_wmask  in  MASK_W  per-lane write enable.
- a_rsp_valid  out  1  read data for A is valid this cycle.
- a_rsp_rdata  out  DATA_W  read data for A.
- b_req_valid, b_req_ready, b_req_write, b_req_addr, b_req_wdata, b_req_wmask, b_rsp_valid, b_rsp_rdata: same as A, for requester B.
- sram_en  out  1  macro enable.
- sram_wmode  out  1  macro write mode.
- sram_addr  out  ADDR_W  macro address.
- sram_wmask  out  MASK_W  macro write mask.
- sram_wdata  out  DATA_W  macro write data.
- sram_rdata  in  DATA_W  macro read data, valid the cycle after a read enable.
- init_done  out  1  arbiter is in RUN state.

Behaviour:
- Reset is asynchronous and active-high. Clock and reset ports are named clock and reset.
- FSM states: INIT and RUN. Reset state is INIT when SRAM_ARB_INIT_EN is defined, RUN otherwise.
- INIT state:
  - Counter init_cnt (ADDR_W bits) resets to 0.
  - Every cycle drives sram_en=1, sram_wmode=1, sram_addr=init_cnt, sram_wdata=0, sram_wmask=all ones.
  - init_cnt increments each cycle.
  - When init_cnt==DEPTH-1 the write completes and the next state is RUN. The sweep takes exactly DEPTH cycles.
  - Both req_ready outputs are 0; requests are held off, not dropped.
- RUN state arbitration:
  - Register prio resets to "A first".
  - If only one requester is valid, it is granted.
  - If both are valid, the requester indicated by prio is granted.
  - On every grant, prio flips to the non-granted requester. A requester therefore waits at most 1 cycle under contention.
  - x_req_ready is combinational from state, prio and the other requester's valid. It does not depend on the requester's own valid.
- Handshake:
  - A request fires when valid && ready. At most one request fires per cycle.
  - sram_* are driven combinationally from the fired request: sram_en=1, sram_wmode=write, addr, wdata and wmask passed through.
  - When no request fires, sram_en=0 and the other sram_* outputs are don't-care (drive 0).
- Read response:
  - Registers rsp_a and rsp_b capture "a read fired for this requester".
  - x_rsp_valid is asserted exactly 1 cycle after the read handshake.
  - x_rsp_rdata = sram_rdata, combinational passthrough, valid only while x_rsp_valid is high.
  - Responses have no backpressure; the requester must accept.
  - A write produces no response.
- Back-to-back reads from the same or alternating requesters sustain 1 access per cycle. Responses return in grant order.
- Reset mid-operation: in-flight response flags clear immediately, no rsp_valid is emitted, and the INIT sweep restarts from 0 when the feature is enabled.
- Reset values of outputs: a/b_req_ready=0 (INIT) or RUN-derived, a/b_rsp_valid=0, sram_en=1 in INIT or 0 in RUN with no valid requests, init_done=0 (feature on) or 1 (feature off).
- Read and write to the same address in consecutive cycles: ordering follows grant order. A read after a granted write returns the new data.

Optional Feature:
SRAM_ARB_INIT_EN
- Defined: INIT state and init_cnt exist. After reset the zero sweep runs for DEPTH cycles, then init_done=1.
- Undefined: no counter, no INIT state. The FSM resets directly into RUN, init_done is constant 1, and SRAM contents are left uninitialised.

Test Plan:
All scenarios use defaults (ADDR_W=9, DEPTH=512, DATA_W=128, MASK_W=4).
1. Feature on: deassert reset, hold a_req_valid=1 -> sram_en=wmode=1 for 512 cycles over addr 0..511 with mask 4'hF and data 0. init_done rises on cycle 512 and a_req_ready rises with it. A read of addr 511 returns 0.
2. Write from A: addr 9'h010, wdata 128'h1111_..., wmask 4'b0101. Then read addr 9'h010 from B -> b_rsp_valid 1 cycle later with only lanes 0 and 2 updated, other lanes 0.
3. Both valid with reads for 6 consecutive cycles -> grants A,B,A,B,A,B. Each rsp_valid arrives 1 cycle after its grant on the matching requester only.
4. Only B valid for 4 cycles, then both valid -> B is granted 4 times, then A is granted first under contention.
5. Assert reset the cycle after A's read handshake -> a_rsp_valid stays 0. The INIT sweep restarts at addr 0.
6. Feature off: deassert reset -> init_done=1 and a_req_ready=1 in the first cycle. A read at addr 5 yields a_rsp_valid exactly 1 cycle later.

Source files
------------

// File: rtl/sram_rw_arbiter.sv
// Round-robin arbiter sharing one single-port RW SRAM macro between requesters A and B.
// Define SRAM_ARB_INIT_EN to zero every entry after reset before requests are accepted.
module sram_rw_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512,
    parameter int DATA_W = 128,
    parameter int MASK_W = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_write,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    input  logic [MASK_W-1:0] a_req_wmask,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rsp_rdata,

    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_write,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_wdata,
    input  logic [MASK_W-1:0] b_req_wmask,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rsp_rdata,

    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,

    output logic              init_done
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic PRIO_A = 1'b0;
    localparam logic PRIO_B = 1'b1;

`ifdef SRAM_ARB_INIT_EN
    localparam state_t ST_RESET = ST_INIT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
`else
    localparam state_t ST_RESET = ST_RUN;
`endif

    if ((DEPTH > (2 ** ADDR_W)) || ((DATA_W % MASK_W) != 0)) begin : g_param_chk
        $error("sram_rw_arbiter: DEPTH exceeds address space or DATA_W not divisible by MASK_W");
    end

    state_t state_r;
    state_t state_nxt_s;
    logic   prio_r;
    logic   prio_nxt_s;
    logic   rsp_a_r;
    logic   rsp_b_r;
    logic   run_s;
    logic   a_fire_s;
    logic   b_fire_s;

`ifdef SRAM_ARB_INIT_EN
    logic [ADDR_W-1:0] init_cnt_r;
`endif

    // Grant decode: ready depends only on state, priority and the other side's valid.
    always_comb begin
        run_s       = (state_r == ST_RUN);
        a_req_ready = run_s && (!b_req_valid || (prio_r == PRIO_A));
        b_req_ready = run_s && (!a_req_valid || (prio_r == PRIO_B));
        a_fire_s    = a_req_valid && a_req_ready;
        b_fire_s    = b_req_valid && b_req_ready;
    end

    // Next-state: the sweep leaves INIT right after writing the last entry.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
`ifdef SRAM_ARB_INIT_EN
                if (init_cnt_r == LAST_ADDR) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
`else
                state_nxt_s = ST_RUN;
`endif
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_RESET;
        endcase
    end

    // Priority hand-off: after any grant the other requester wins the next tie.
    always_comb begin
        prio_nxt_s = prio_r;
        if (a_fire_s) begin
            prio_nxt_s = PRIO_B;
        end else if (b_fire_s) begin
            prio_nxt_s = PRIO_A;
        end else begin
            prio_nxt_s = prio_r;
        end
    end

    // SRAM command mux: zero-sweep writes in INIT, otherwise the fired request.
    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = {ADDR_W{1'b0}};
        sram_wmask = {MASK_W{1'b0}};
        sram_wdata = {DATA_W{1'b0}};
        if (state_r == ST_INIT) begin
`ifdef SRAM_ARB_INIT_EN
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = init_cnt_r;
            sram_wmask = {MASK_W{1'b1}};
`else
            sram_en    = 1'b0;
`endif
        end else if (a_fire_s) begin
            sram_en    = 1'b1;
            sram_wmode = a_req_write;
            sram_addr  = a_req_addr;
            sram_wmask = a_req_wmask;
            sram_wdata = a_req_wdata;
        end else if (b_fire_s) begin
            sram_en    = 1'b1;
            sram_wmode = b_req_write;
            sram_addr  = b_req_addr;
            sram_wmask = b_req_wmask;
            sram_wdata = b_req_wdata;
        end else begin
            sram_en    = 1'b0;
        end
    end

    // State and priority registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_RESET;
            prio_r  <= PRIO_A;
        end else begin
            state_r <= state_nxt_s;
            prio_r  <= prio_nxt_s;
        end
    end

    // Read-response flags: the macro returns data one cycle after a read fires.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_a_r <= 1'b0;
            rsp_b_r <= 1'b0;
        end else begin
            rsp_a_r <= a_fire_s && !a_req_write;
            rsp_b_r <= b_fire_s && !b_req_write;
        end
    end

`ifdef SRAM_ARB_INIT_EN
    // Sweep address counter, restarting from zero on every reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            init_cnt_r <= {ADDR_W{1'b0}};
        end else if (state_r == ST_INIT) begin
            init_cnt_r <= init_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    assign init_done = (state_r == ST_RUN);
`else
    assign init_done = 1'b1;
`endif

    assign a_rsp_valid = rsp_a_r;
    assign b_rsp_valid = rsp_b_r;
    assign a_rsp_rdata = sram_rdata;
    assign b_rsp_rdata = sram_rdata;

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Directed self-checking bench for sram_rw_arbiter with a behavioural RW SRAM macro.
// Honours SRAM_ARB_INIT_EN to select the zero-sweep or direct-RUN expectations.
module tb_sram_rw_arbiter;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 512;
    localparam int DATA_W = 128;
    localparam int MASK_W = 4;
    localparam int LANE_W = DATA_W / MASK_W;

`ifdef SRAM_ARB_INIT_EN
    localparam logic [DATA_W-1:0] PRELOAD = {4{32'hDEAD_BEEF}};
`else
    localparam logic [DATA_W-1:0] PRELOAD = {DATA_W{1'b0}};
`endif
    localparam logic [DATA_W-1:0] WDATA_ONES = {4{32'h1111_1111}};
    localparam logic [DATA_W-1:0] EXP_MASKED = {32'h0000_0000, 32'h1111_1111, 32'h0000_0000, 32'h1111_1111};
    localparam logic [DATA_W-1:0] WDATA_RAW  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              a_req_valid, a_req_ready, a_req_write, a_rsp_valid;
    logic [ADDR_W-1:0] a_req_addr;
    logic [DATA_W-1:0] a_req_wdata, a_rsp_rdata;
    logic [MASK_W-1:0] a_req_wmask;
    logic              b_req_valid, b_req_ready, b_req_write, b_rsp_valid;
    logic [ADDR_W-1:0] b_req_addr;
    logic [DATA_W-1:0] b_req_wdata, b_rsp_rdata;
    logic [MASK_W-1:0] b_req_wmask;
    logic              sram_en, sram_wmode, init_done;
    logic [ADDR_W-1:0] sram_addr;
    logic [MASK_W-1:0] sram_wmask;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    sram_rw_arbiter #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .MASK_W(MASK_W)
    ) dut (
        .clock(clock), .reset(reset),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_write(a_req_write),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata), .a_req_wmask(a_req_wmask),
        .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_write(b_req_write),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata), .b_req_wmask(b_req_wmask),
        .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
        .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
        .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .init_done(init_done)
    );

    always #5 clock = ~clock;

    // Behavioural macro: per-lane masked write, registered read; reset preloads contents.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= PRELOAD;
            sram_rdata <= {DATA_W{1'b0}};
        end else if (sram_en) begin
            if (sram_wmode) begin
                for (int l = 0; l < MASK_W; l++)
                    if (sram_wmask[l]) mem[sram_addr][l*LANE_W +: LANE_W] <= sram_wdata[l*LANE_W +: LANE_W];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic v, input logic w, input logic [ADDR_W-1:0] ad,
                           input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
        a_req_valid = v; a_req_write = w; a_req_addr = ad; a_req_wdata = d; a_req_wmask = m;
    endtask

    task automatic drive_b(input logic v, input logic w, input logic [ADDR_W-1:0] ad,
                           input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
        b_req_valid = v; b_req_write = w; b_req_addr = ad; b_req_wdata = d; b_req_wmask = m;
    endtask

    initial begin
        logic prev_a;
        logic prev_b;
        logic ga;
        drive_a(1'b0, 1'b0, 9'h000, 128'h0, 4'h0);
        drive_b(1'b0, 1'b0, 9'h000, 128'h0, 4'h0);
        repeat (2) @(negedge clock);
        #1;
        check_eq("rst_a_rsp_valid", DATA_W'(a_rsp_valid), DATA_W'(1'b0));
        check_eq("rst_b_rsp_valid", DATA_W'(b_rsp_valid), DATA_W'(1'b0));
`ifdef SRAM_ARB_INIT_EN
        check_eq("rst_init_done", DATA_W'(init_done), DATA_W'(1'b0));
        check_eq("rst_a_ready", DATA_W'(a_req_ready), DATA_W'(1'b0));
        check_eq("rst_sram_en", DATA_W'(sram_en), DATA_W'(1'b1));
        check_eq("rst_sram_addr", DATA_W'(sram_addr), DATA_W'(9'h000));
`else
        check_eq("rst_init_done", DATA_W'(init_done), DATA_W'(1'b1));
        check_eq("rst_a_ready", DATA_W'(a_req_ready), DATA_W'(1'b1));
        check_eq("rst_sram_en", DATA_W'(sram_en), DATA_W'(1'b0));
`endif
        @(negedge clock);
        reset = 1'b0;

`ifdef SRAM_ARB_INIT_EN
        // Zero sweep with A requesting a read of the last entry throughout.
        drive_a(1'b1, 1'b0, 9'h1FF, 128'h0, 4'h0);
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            check_eq("init_sram_en", DATA_W'(sram_en), DATA_W'(1'b1));
            check_eq("init_wmode", DATA_W'(sram_wmode), DATA_W'(1'b1));
            check_eq("init_addr", DATA_W'(sram_addr), DATA_W'(i));
            check_eq("init_wmask", DATA_W'(sram_wmask), DATA_W'(4'hF));
            check_eq("init_wdata", sram_wdata, 128'h0);
            check_eq("init_a_ready", DATA_W'(a_req_ready), DATA_W'(1'b0));
            check_eq("init_done_low", DATA_W'(init_done), DATA_W'(1'b0));
            @(negedge clock);
        end
        #1;
        check_eq("init_done_rise", DATA_W'(init_done), DATA_W'(1'b1));
        check_eq("init_a_ready_rise", DATA_W'(a_req_ready), DATA_W'(1'b1));
        check_eq("init_held_rd_wmode", DATA_W'(sram_wmode), DATA_W'(1'b0));
        check_eq("init_held_rd_addr", DATA_W'(sram_addr), DATA_W'(9'h1FF));
        @(negedge clock);
        drive_a(1'b0, 1'b0, 9'h000, 128'h0, 4'h0);
        #1;
        check_eq("init_rd511_valid", DATA_W'(a_rsp_valid), DATA_W'(1'b1));
        check_eq("init_rd511_data", a_rsp_rdata, 128'h0);
        @(negedge clock);
`endif

        // First RUN cycle: read of addr 5 from A.
        drive_a(1'b1, 1'b0, 9'h005, 128'h0, 4'h0);
        #1;
        check_eq("rd5_init_done", DATA_W'(init_done), DATA_W'(1'b1));
        check_eq("rd5_a_ready", DATA_W'(a_req_ready), DATA_W'(1'b1));
        check_eq("rd5_sram_en", DATA_W'(sram_en), DATA_W'(1'b1));
        check_eq("rd5_wmode", DATA_W'(sram_wmode), DATA_W'(1'b0));
        check_eq("rd5_addr", DATA_W'(sram_addr), DATA_W'(9'h005));
        check_eq("rd5_rsp_early", DATA_W'(a_rsp_valid), DATA_W'(1'b0));
        @(negedge clock);
        drive_a(1'b0, 1'b0, 9'h000, 128'h0, 4'h0);
        #1;
        check_eq("rd5_rsp_valid", DATA_W'(a_rsp_valid), DATA_W'(1'b1));
        check_eq("rd5_b_rsp_quiet", DATA_W'(b_rsp_valid), DATA_W'(1'b0));
        check_eq("rd5_rdata", a_rsp_rdata, 128'h0);
        check_eq("idle_sram_en", DATA_W'(sram_en), DATA_W'(1'b0));
        @(negedge clock);
        #1;
        check_eq("rd5_rsp_single", DATA_W'(a_rsp_valid), DATA_W'(1'b0));

        // Masked write from A, then read back from B.
        @(negedge clock);
        drive_a(1'b1, 1'b1, 9'h010, WDATA_ONES, 4'b0101);
        #1;
        check_eq("wr_a_ready", DATA_W'(a_req_ready), DATA_W'(1'b1));
        check_eq("wr_wmode", DATA_W'(sram_wmode), DATA_W'(1'b1));
        check_eq("wr_wmask", DATA_W'(sram_wmask), DATA_W'(4'b0101));
        check_eq("wr_wdata", sram_wdata, WDATA_ONES);
        check_eq("wr_addr", DATA_W'(sram_addr), DATA_W'(9'h010));
        @(negedge clock);
        drive_a(1'b0, 1'b0, 9'h000, 128'h0, 4'h0);
        drive_b(1'b1, 1'b0, 9'h010, 128'h0, 4'h0);
        #1;
        check_eq("wr_no_rsp", DATA_W'(a_rsp_valid), DATA_W'(1'b0));
        check_eq("rdb_ready", DATA_W'(b_req_ready), DATA_W'(1'b1));
        check_eq("rdb_addr", DATA_W'(sram_addr), DATA_W'(9'h010));
        check_eq("rdb_wmode", DATA_W'(sram_wmode), DATA_W'(1'b0));
        @(negedge clock);
        drive_b(1'b0, 1'b0, 9'h000, 128'h0, 4'h0);
        #1;
        check_eq("rdb_rsp_valid", DATA_W'(b_rsp_valid), DATA_W'(1'b1));
        check_eq("rdb_a_quiet", DATA_W'(a_rsp_valid), DATA_W'(1'b0));
        check_eq("rdb_masked_data", b_rsp_rdata, EXP_MASKED);
        @(negedge clock);

        // Contention: both read for six cycles, grants alternate starting with A.
        drive_a(1'b1, 1'b0, 9'h010, 128'h0, 4'h0);
        drive_b(1'b1, 1'b0, 9'h005, 128'h0, 4'h0);
        prev_a = 1'b0;
        prev_b = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            ga = ((k % 2) == 0);
            check_eq("rr_a_ready", DATA_W'(a_req_ready), DATA_W'(ga));
            check_eq("rr_b_ready", DATA_W'(b_req_ready), DATA_W'(!ga));
            check_eq("rr_addr", DATA_W'(sram_addr), ga ? DATA_W'(9'h010) : DATA_W'(9'h005));
            check_eq("rr_a_rsp", DATA_W'(a_rsp_valid), DATA_W'(prev_a));
            check_eq("rr_b_rsp", DATA_W'(b_rsp_valid), DATA_W'(prev_b));
            if (prev_a) check_eq("rr_a_rdata", a_rsp_rdata, EXP_MASKED);
            if (prev_b) check_eq("rr_b_rdata", b_rsp_rdata, 128'h0);
            prev_a = ga;
            prev_b = !ga;
            @(negedge clock);
        end
        drive_a(1'b0, 1'b0, 9'h000, 128'h0, 4'h0);
        drive_b(1'b0, 1'b0, 9'h000, 128'h0, 4'h0);
        #1;
        check_eq("rr_last_b_rsp", DATA_W'(b_rsp_valid), DATA_W'(1'b1));
        check_eq("rr_last_a_quiet", DATA_W'(a_rsp_valid), DATA_W'(1'b0));
        @(negedge clock);

        // B alone four times, then contention goes to A first.
        drive_b(1'b1, 1'b0, 9'h005, 128'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("solo_b_ready", DATA_W'(b_req_ready), DATA_W'(1'b1));
            check_eq("solo_b_en", DATA_W'(sram_en), DATA_W'(1'b1));
            check_eq("solo_b_addr", DATA_W'(sram_addr), DATA_W'(9'h005));
            @(negedge clock);
        end
        drive_a(1'b1, 1'b0, 9'h010, 128'h0, 4'h0);
        #1;
        check_eq("solo_then_a_ready", DATA_W'(a_req_ready), DATA_W'(1'b1));
        check_eq("solo_then_b_wait", DATA_W'(b_req_ready), DATA_W'(1'b0));
        check_eq("solo_then_addr", DATA_W'(sram_addr), DATA_W'(9'h010));
        @(negedge clock);
        #1;
        check_eq("solo_next_b_ready", DATA_W'(b_req_ready), DATA_W'(1'b1));
        check_eq("solo_next_a_wait", DATA_W'(a_req_ready), DATA_W'(1'b0));
        check_eq("solo_next_a_rsp", DATA_W'(a_rsp_valid), DATA_W'(1'b1));
        @(negedge clock);
        drive_a(1'b0, 1'b0, 9'h000, 128'h0, 4'h0);
        drive_b(1'b0, 1'b0, 9'h000, 128'h0, 4'h0);
        @(negedge clock);

        // Full write from A followed immediately by a read of the same entry from B.
        drive_a(1'b1, 1'b1, 9'h020, WDATA_RAW, 4'hF);
        @(negedge clock);
        drive_a(1'b0, 1'b0, 9'h000, 128'h0, 4'h0);
        drive_b(1'b1, 1'b0, 9'h020, 128'h0, 4'h0);
        #1;
        check_eq("raw_b_ready", DATA_W'(b_req_ready), DATA_W'(1'b1));
        @(negedge clock);
        drive_b(1'b0, 1'b0, 9'h000, 128'h0, 4'h0);
        #1;
        check_eq("raw_rsp_valid", DATA_W'(b_rsp_valid), DATA_W'(1'b1));
        check_eq("raw_rdata", b_rsp_rdata, WDATA_RAW);
        @(negedge clock);

        // Reset right after A's read handshake drops the pending response.
        drive_a(1'b1, 1'b0, 9'h020, 128'h0, 4'h0);
        #1;
        check_eq("rstmid_a_ready", DATA_W'(a_req_ready), DATA_W'(1'b1));
        @(negedge clock);
        drive_a(1'b0, 1'b0, 9'h000, 128'h0, 4'h0);
        reset = 1'b1;
        #1;
        check_eq("rstmid_rsp_cleared", DATA_W'(a_rsp_valid), DATA_W'(1'b0));
`ifdef SRAM_ARB_INIT_EN
        check_eq("rstmid_init_done", DATA_W'(init_done), DATA_W'(1'b0));
        check_eq("rstmid_sweep_addr", DATA_W'(sram_addr), DATA_W'(9'h000));
`endif
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("rstmid_rsp_still0", DATA_W'(a_rsp_valid), DATA_W'(1'b0));
`ifdef SRAM_ARB_INIT_EN
        check_eq("rstmid_restart0", DATA_W'(sram_addr), DATA_W'(9'h000));
        @(negedge clock);
        #1;
        check_eq("rstmid_restart1", DATA_W'(sram_addr), DATA_W'(9'h001));
`else
        check_eq("rstmid_init_done", DATA_W'(init_done), DATA_W'(1'b1));
        check_eq("rstmid_idle_en", DATA_W'(sram_en), DATA_W'(1'b0));
`endif
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
